// File: rtl/qtcore_scan_loader.sv
// Byte-stream loader for the qtcore scan chain plus run controller; 1+8 cycles per byte, run ends on halt/timeout.
// Stalls in LOAD_WAIT with scan_enable low until byte_valid; readback_valid is a strobe with no backpressure.
module qtcore_scan_loader #(
    parameter int CHAIN_BITS  = 200,
    parameter int RUN_TIMEOUT = 65535,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             run_start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             scan_enable,
    output logic             scan_in,
    input  logic             scan_out,
    output logic             proc_en,
    input  logic             halt,
    output logic [7:0]       readback_byte,
    output logic             readback_valid,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] run_cycles
);
    localparam int                NBYTES      = CHAIN_BITS / 8;
    localparam int                BC_W        = $clog2(NBYTES + 1);
    localparam logic [BC_W-1:0]   LAST_BYTE   = BC_W'(NBYTES);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(RUN_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic [2:0] {IDLE, LOAD_WAIT, SHIFT, RUN, FINISH} state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [7:0]       capture;
    logic [2:0]       bit_cnt;
    logic [BC_W-1:0]  byte_cnt;
    logic [CNT_W-1:0] run_next;
    logic             timeout_now;

    assign run_next    = (run_cycles == CNT_MAX) ? run_cycles : run_cycles + CNT_W'(1);
    assign timeout_now = (RUN_TIMEOUT != 0) && (run_next >= TIMEOUT_CNT);

    // Gated so the chain input is quiet whenever the chain is not shifting.
    assign scan_in = scan_enable & shreg[7];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            byte_ready     <= 1'b0;
            scan_enable    <= 1'b0;
            proc_en        <= 1'b0;
            readback_valid <= 1'b0;
            readback_byte  <= 8'h00;
            done           <= 1'b0;
            timed_out      <= 1'b0;
            run_cycles     <= '0;
            byte_cnt       <= '0;
            bit_cnt        <= 3'd0;
            shreg          <= 8'h00;
            capture        <= 8'h00;
        end else begin
            readback_valid <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD_WAIT;
                        byte_cnt   <= '0;
                        byte_ready <= 1'b1;
                    end else if (run_start) begin
                        state      <= RUN;
                        run_cycles <= '0;
                        timed_out  <= 1'b0;
                        proc_en    <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    if (byte_valid && byte_ready) begin
                        shreg       <= byte_in;
                        bit_cnt     <= 3'd0;
                        byte_ready  <= 1'b0;
                        scan_enable <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[6:0], 1'b0};
                    capture <= {capture[6:0], scan_out};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        readback_byte  <= {capture[6:0], scan_out};
                        readback_valid <= 1'b1;
                        byte_cnt       <= byte_cnt + BC_W'(1);
                        scan_enable    <= 1'b0;
                        if (byte_cnt + BC_W'(1) == LAST_BYTE) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD_WAIT;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    run_cycles <= run_next;
                    // Halt takes priority so a program halting on the last allowed cycle is not flagged.
                    if (halt) begin
                        proc_en <= 1'b0;
                        state   <= FINISH;
                        done    <= 1'b1;
                    end else if (timeout_now) begin
                        proc_en   <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= FINISH;
                        done      <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qtcore_scan_loader.sv
// Directed bench for qtcore_scan_loader: cycle table for a 16-bit chain load plus multi-cycle run/corner sequences.
module tb_qtcore_scan_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0, run_start = 1'b0, byte_valid = 1'b0, halt = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        chain_load = 1'b1;
    logic [15:0] chain;
    logic        scan_out;

    logic        byte_ready, scan_enable, scan_in, proc_en, readback_valid, busy, done, timed_out;
    logic [7:0]  readback_byte;
    logic [15:0] run_cycles;
    logic        t_byte_ready, t_scan_enable, t_scan_in, t_proc_en, t_readback_valid, t_busy, t_done, t_timed_out;
    logic [7:0]  t_readback_byte;
    logic [15:0] t_run_cycles;

    int checks = 0, errors = 0;
    int rb_n = 0, done_cnt = 0, t_done_cnt = 0;
    logic [7:0] rb_mem [16];

    always #5 clk = ~clk;

    qtcore_scan_loader #(.CHAIN_BITS(16), .RUN_TIMEOUT(1000), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .proc_en(proc_en), .halt(halt), .readback_byte(readback_byte),
        .readback_valid(readback_valid), .busy(busy), .done(done),
        .timed_out(timed_out), .run_cycles(run_cycles));

    qtcore_scan_loader #(.CHAIN_BITS(16), .RUN_TIMEOUT(10), .CNT_W(16)) u_to (
        .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(t_byte_ready),
        .scan_enable(t_scan_enable), .scan_in(t_scan_in), .scan_out(scan_out),
        .proc_en(t_proc_en), .halt(halt), .readback_byte(t_readback_byte),
        .readback_valid(t_readback_valid), .busy(t_busy), .done(t_done),
        .timed_out(t_timed_out), .run_cycles(t_run_cycles));

    // 16-bit processor chain model driven by u_dut
    always @(posedge clk) begin
        if (chain_load) chain <= 16'h1234;
        else if (scan_enable) chain <= {chain[14:0], scan_in};
    end
    assign scan_out = chain[15];

    always @(negedge clk) begin
        if (readback_valid) begin
            rb_mem[rb_n % 16] <= readback_byte;
            rb_n <= rb_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (t_done) t_done_cnt <= t_done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic       ls, bv;
        logic [7:0] bi;
        logic       rdy, se, si, rv, bsy, dn;
        logic [7:0] rb;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic ls, logic bv, logic [7:0] bi, logic rdy, logic se,
                                logic si, logic rv, logic bsy, logic dn, logic [7:0] rb);
        vec_t v;
        v.ls = ls; v.bv = bv; v.bi = bi; v.rdy = rdy; v.se = se;
        v.si = si; v.rv = rv; v.bsy = bsy; v.dn = dn; v.rb = rb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load_start = 1'b0; run_start = 1'b0; byte_valid = 1'b0;
        byte_in = 8'h00; halt = 1'b0; chain_load = 1'b1;
        tick(); tick();
        rst = 1'b0; chain_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < 100; i++) begin
            if (byte_ready) break;
            tick();
        end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL send_byte: byte_ready got 0 required 1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    // Load A5,3C into the chain preset to 1234, with an optional idle gap between bytes.
    task automatic full_load(input string tag, input int gap);
        int rb0, d0, viol;
        rb0 = rb_n; d0 = done_cnt; viol = 0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_byte(8'hA5);
        if (gap > 0) begin
            for (int i = 0; i < 20 && !byte_ready; i++) tick();
            for (int i = 0; i < gap; i++) begin
                if (scan_enable) viol++;
                tick();
            end
            check({tag, "_gap_se"}, viol, 0);
        end
        send_byte(8'h3C);
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        tick();
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_rb_cnt"}, rb_n - rb0, 2);
        check({tag, "_rb0"}, rb_mem[rb0 % 16], 8'h12);
        check({tag, "_rb1"}, rb_mem[(rb0 + 1) % 16], 8'h34);
        check({tag, "_chain"}, chain, 16'hA53C);
    endtask

    task automatic run_test(input string tag, input bit use_to, input int halt_at,
                            input int exp_cyc, input bit exp_to);
        int pe_cnt, overlap, d0;
        logic pe, se;
        pe_cnt = 0; overlap = 0;
        d0 = use_to ? t_done_cnt : done_cnt;
        run_start = 1'b1; tick(); run_start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            pe = use_to ? t_proc_en : proc_en;
            se = use_to ? t_scan_enable : scan_enable;
            if (pe) pe_cnt++;
            if (pe && se) overlap++;
            halt = (halt_at != 0) && (pe_cnt >= halt_at);
            tick();
        end
        check({tag, "_pe_cycles"}, pe_cnt, exp_cyc);
        check({tag, "_run_cycles"}, use_to ? t_run_cycles : run_cycles, exp_cyc);
        check({tag, "_timed_out"}, use_to ? t_timed_out : timed_out, exp_to);
        check({tag, "_done_cnt"}, (use_to ? t_done_cnt : done_cnt) - d0, 1);
        check({tag, "_se_pe_overlap"}, overlap, 0);
        do_reset();
    endtask

    initial begin
        int pe_cnt;

        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 1, 8'hA5, 1, 0, 0, 0, 1, 0, 8'h00);
        tbl[2]  = mk(0, 1, 8'h3C, 0, 1, 1, 0, 1, 0, 8'h00);
        tbl[3]  = mk(0, 1, 8'h3C, 0, 1, 0, 0, 1, 0, 8'h00);
        tbl[4]  = mk(0, 1, 8'h3C, 0, 1, 1, 0, 1, 0, 8'h00);
        tbl[5]  = mk(0, 1, 8'h3C, 0, 1, 0, 0, 1, 0, 8'h00);
        tbl[6]  = mk(0, 1, 8'h3C, 0, 1, 0, 0, 1, 0, 8'h00);
        tbl[7]  = mk(0, 1, 8'h3C, 0, 1, 1, 0, 1, 0, 8'h00);
        tbl[8]  = mk(0, 1, 8'h3C, 0, 1, 0, 0, 1, 0, 8'h00);
        tbl[9]  = mk(0, 1, 8'h3C, 0, 1, 1, 0, 1, 0, 8'h00);
        tbl[10] = mk(0, 1, 8'h3C, 1, 0, 0, 1, 1, 0, 8'h12);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h12);
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h12);
        tbl[13] = mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 8'h12);
        tbl[14] = mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 8'h12);
        tbl[15] = mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 8'h12);
        tbl[16] = mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 8'h12);
        tbl[17] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h12);
        tbl[18] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h12);
        tbl[19] = mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h34);
        tbl[20] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h34);

        do_reset();
        check("reset_byte_ready", byte_ready, 0);
        check("reset_scan_enable", scan_enable, 0);
        check("reset_scan_in", scan_in, 0);
        check("reset_proc_en", proc_en, 0);
        check("reset_rb_valid", readback_valid, 0);
        check("reset_rb_byte", readback_byte, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_timed_out", timed_out, 0);
        check("reset_run_cycles", run_cycles, 0);

        // Back-to-back load, one table row per clock cycle
        for (int i = 0; i < 21; i++) begin
            check($sformatf("vec%0d_rdy", i), byte_ready, tbl[i].rdy);
            check($sformatf("vec%0d_se", i), scan_enable, tbl[i].se);
            check($sformatf("vec%0d_si", i), scan_in, tbl[i].si);
            check($sformatf("vec%0d_rv", i), readback_valid, tbl[i].rv);
            check($sformatf("vec%0d_rb", i), readback_byte, tbl[i].rb);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("vec%0d_done", i), done, tbl[i].dn);
            load_start = tbl[i].ls;
            byte_valid = tbl[i].bv;
            byte_in    = tbl[i].bi;
            tick();
        end
        check("b2b_chain", chain, 16'hA53C);

        do_reset();
        full_load("stall", 20);

        // Reset during the 4th shift cycle of the first byte
        do_reset();
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_byte(8'hA5);
        tick(); tick(); tick();
        check("midshift_se_before", scan_enable, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midshift_se", scan_enable, 0);
        check("midshift_rdy", byte_ready, 0);
        check("midshift_busy", busy, 0);
        chain_load = 1'b1; tick(); chain_load = 1'b0;
        full_load("after_rst", 0);

        do_reset();
        run_test("halt37", 0, 37, 37, 0);
        run_test("halt_entry", 0, 1, 1, 0);
        run_test("timeout", 1, 0, 10, 1);
        run_test("halt_and_to", 1, 10, 10, 0);

        // Load and run requested together: load wins
        load_start = 1'b1; run_start = 1'b1; tick();
        load_start = 1'b0; run_start = 1'b0;
        check("both_start_rdy", byte_ready, 1);
        pe_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (proc_en) pe_cnt++;
            tick();
        end
        check("both_start_no_pe", pe_cnt, 0);
        check("both_start_busy", busy, 1);

        // run_start while shifting is dropped
        do_reset();
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_byte(8'hA5);
        tick();
        run_start = 1'b1; tick(); run_start = 1'b0;
        pe_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (proc_en) pe_cnt++;
            tick();
        end
        check("shift_run_no_pe", pe_cnt, 0);
        check("shift_run_rdy", byte_ready, 1);
        check("shift_run_rb", readback_byte, 8'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
